// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared types and helpers for the 2-way cache controller.
//   state_t       - controller FSM states
//   way_t         - way number (2 ways -> 1 bit)
//   s_mask()      - write-enable bits per way for a given log2 line size
//   DATA_SRC_*    - data array write source select encodings
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_t;

    typedef logic way_t;

    localparam logic DATA_SRC_CPU  = 1'b0;
    localparam logic DATA_SRC_PMEM = 1'b1;

    function automatic int unsigned s_mask(input int unsigned s_offset);
        return 32'd1 << s_offset;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU request/response and physical-memory line port bundle.
//   mem_read/mem_write/mem_byte_enable : CPU request (held until mem_resp)
//   mem_resp                           : CPU response pulse
//   pmem_read/pmem_write/pmem_addr_sel : line fill / writeback request
//   pmem_resp                          : cacheline adaptor done
// Modports:
//   slave  - the cache controller
//   master - the surrounding system (CPU side plus cacheline adaptor)
interface cache_ctrl_if
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned s_offset = 5
);
    logic                          mem_read;
    logic                          mem_write;
    logic [s_mask(s_offset)-1:0]   mem_byte_enable;
    logic                          mem_resp;
    logic                          pmem_read;
    logic                          pmem_write;
    logic                          pmem_addr_sel;
    logic                          pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel
    );
endinterface

// File: rtl/cache_perf_cnt.sv
// cache_perf_cnt: saturating hit / miss / writeback counters.
//   clk, rst   : clock, asynchronous active-low reset
//   idle       : controller is in IDLE (arms the first-check flag)
//   check_ev   : controller is in CHECK this cycle
//   hit_ev     : CHECK with a live request and a tag hit
//   miss_ev    : CHECK with a live request and a miss
//   wb_ev      : WRITEBACK completing this cycle
//   hit_cnt, miss_cnt, wb_cnt : counter values
// Only the first CHECK of a request may count as a hit, so the re-check
// after a line fill is not double counted.
module cache_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             check_ev,
    input  logic             hit_ev,
    input  logic             miss_ev,
    input  logic             wb_ev,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);
    logic first_chk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_chk <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            wb_cnt    <= '0;
        end else begin
            if (idle) begin
                first_chk <= 1'b1;
            end else if (check_ev) begin
                first_chk <= 1'b0;
            end
            if (hit_ev && first_chk && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_ev && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
            if (wb_ev && (wb_cnt != '1)) begin
                wb_cnt <= wb_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: control FSM for a 2-way set-associative cache.
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : CPU request/response and pmem line port
//   hit, valid, dirty : per-way status of the indexed set
//   lru               : way to evict for the indexed set
//   data_we0/1        : per-way byte write masks
//   data_src          : data array write source (CPU / pmem line)
//   load_tag, set_valid, set_dirty, clr_dirty : per-way array strobes
//   load_lru, lru_in  : LRU array update
//   victim            : registered eviction way
// Optional: define CACHE_PERF_CNT_EN to add hit_cnt/miss_cnt/wb_cnt outputs.
// Only state and victim are flops; every other output decodes state and
// inputs, so an asynchronous reset drops pmem requests immediately.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    cache_ctrl_if.slave                 bus,
    input  logic [1:0]                  hit,
    input  logic [1:0]                  valid,
    input  logic [1:0]                  dirty,
    input  logic                        lru,
    output logic [s_mask(s_offset)-1:0] data_we0,
    output logic [s_mask(s_offset)-1:0] data_we1,
    output logic                        data_src,
    output logic [1:0]                  load_tag,
    output logic [1:0]                  set_valid,
    output logic [1:0]                  set_dirty,
    output logic [1:0]                  clr_dirty,
    output logic                        load_lru,
    output logic                        lru_in,
    output logic                        victim
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt,
    output logic [CNT_W-1:0]            wb_cnt
`endif
);
    state_t state;
    way_t   victim_q;
    logic   req;
    logic   any_hit;
    way_t   hit_way;

    assign req     = bus.mem_read | bus.mem_write;
    assign any_hit = |hit;
    // hit == 2'b11 cannot legally occur; way 0 takes priority if it does.
    assign hit_way = hit[0] ? 1'b0 : 1'b1;
    assign victim  = victim_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            victim_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) state <= CHECK;
                end
                CHECK: begin
                    if (!req || any_hit) begin
                        state <= IDLE;
                    end else begin
                        victim_q <= lru;
                        state    <= (valid[lru] && dirty[lru]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (bus.pmem_resp) state <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        data_we0          = '0;
        data_we1          = '0;
        data_src          = DATA_SRC_CPU;
        load_tag          = '0;
        set_valid         = '0;
        set_dirty         = '0;
        clr_dirty         = '0;
        load_lru          = 1'b0;
        lru_in            = 1'b0;
        case (state)
            CHECK: begin
                if (req && any_hit) begin
                    bus.mem_resp = 1'b1;
                    load_lru     = 1'b1;
                    lru_in       = ~hit_way;
                    // A simultaneous read and write request is a write.
                    if (bus.mem_write) begin
                        if (hit_way == 1'b0) data_we0 = bus.mem_byte_enable;
                        else                 data_we1 = bus.mem_byte_enable;
                        data_src           = DATA_SRC_CPU;
                        set_dirty[hit_way] = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                if (bus.pmem_resp) clr_dirty[victim_q] = 1'b1;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    if (victim_q == 1'b0) data_we0 = '1;
                    else                  data_we1 = '1;
                    data_src            = DATA_SRC_PMEM;
                    load_tag[victim_q]  = 1'b1;
                    set_valid[victim_q] = 1'b1;
                    clr_dirty[victim_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    cache_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .idle     (state == IDLE),
        .check_ev (state == CHECK),
        .hit_ev   ((state == CHECK) && req && any_hit),
        .miss_ev  ((state == CHECK) && req && !any_hit),
        .wb_ev    ((state == WRITEBACK) && bus.pmem_resp),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl.
// Inputs change #1 after a rising edge; combinational outputs are checked
// mid-cycle, well away from the next edge.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hit, valid, dirty;
    logic        lru;
    logic [31:0] data_we0, data_we1;
    logic        data_src, load_lru, lru_in, victim;
    logic [1:0]  load_tag, set_valid, set_dirty, clr_dirty;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cache_ctrl_if #(.s_offset(5)) bus ();

    cache_ctrl #(.s_offset(5), .s_index(3), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .hit       (hit),
        .valid     (valid),
        .dirty     (dirty),
        .lru       (lru),
        .data_we0  (data_we0),
        .data_we1  (data_we1),
        .data_src  (data_src),
        .load_tag  (load_tag),
        .set_valid (set_valid),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty),
        .load_lru  (load_lru),
        .lru_in    (lru_in),
        .victim    (victim)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.pmem_resp       = 1'b0;
        hit   = 2'b00;
        valid = 2'b00;
        dirty = 2'b00;
        lru   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #12;
        check("rst_mem_resp",  {31'b0, bus.mem_resp},  32'd0);
        check("rst_pmem_rw",   {30'b0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check("rst_victim",    {31'b0, victim},        32'd0);
        check("rst_strobes",   {24'b0, load_tag, set_valid, set_dirty, clr_dirty}, 32'd0);
        rst = 1'b1;
        tick();

        // Write hit in way 0: IDLE cycle then CHECK with response.
        bus.mem_write = 1'b1;
        bus.mem_byte_enable = 32'h0000_00F0;
        hit = 2'b01;
        #1 check("wh_idle_resp", {31'b0, bus.mem_resp}, 32'd0);
        tick();
        check("wh_resp",      {31'b0, bus.mem_resp}, 32'd1);
        check("wh_we0",       data_we0,              32'h0000_00F0);
        check("wh_we1",       data_we1,              32'd0);
        check("wh_set_dirty", {30'b0, set_dirty},    32'd1);
        check("wh_lru",       {30'b0, load_lru, lru_in}, 32'b11);
        check("wh_src",       {31'b0, data_src},     32'd0);
        tick();
        check("wh_back_idle", {31'b0, bus.mem_resp}, 32'd0);
        idle_inputs();
        tick();

        // Reset during FILL: pmem_read must drop without a clock edge.
        bus.mem_read = 1'b1;
        lru = 1'b1;
        tick();
        tick();
        check("rf_in_fill",   {31'b0, bus.pmem_read}, 32'd1);
        check("rf_victim",    {31'b0, victim},        32'd1);
        bus.pmem_resp = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rf_pmem_read", {31'b0, bus.pmem_read}, 32'd0);
        check("rf_load_tag",  {30'b0, load_tag},      32'd0);
        check("rf_victim0",   {31'b0, victim},        32'd0);
        check("rf_we1",       data_we1,               32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
`ifdef CACHE_PERF_CNT_EN
        #1 check("rf_hit_cnt", hit_cnt, 32'd0);
        check("rf_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();

        // Read hit in way 1.
        bus.mem_read = 1'b1;
        hit = 2'b10;
        #1 check("rh_idle_resp", {31'b0, bus.mem_resp}, 32'd0);
        tick();
        check("rh_resp",  {31'b0, bus.mem_resp}, 32'd1);
        check("rh_lru",   {30'b0, load_lru, lru_in}, 32'b10);
        check("rh_we",    data_we0 | data_we1, 32'd0);
        check("rh_dirty", {30'b0, set_dirty}, 32'd0);
        tick();
        check("rh_back_idle", {31'b0, bus.mem_resp}, 32'd0);
        idle_inputs();
        tick();

        // Clean read miss, victim way 1, fill takes 5 cycles.
        bus.mem_read = 1'b1;
        lru = 1'b1;
        tick();
        check("cm_check_resp", {31'b0, bus.mem_resp}, 32'd0);
        tick();
        check("cm_victim", {31'b0, victim}, 32'd1);
        for (int unsigned i = 0; i < 4; i++) begin
            check("cm_fill_wait", {29'b0, bus.pmem_read, bus.pmem_write, load_tag[1]}, 32'b100);
            tick();
        end
        bus.pmem_resp = 1'b1;
        #1;
        check("cm_fill_rd",   {30'b0, bus.pmem_read, bus.pmem_addr_sel}, 32'b10);
        check("cm_we1",       data_we1,            32'hFFFF_FFFF);
        check("cm_we0",       data_we0,            32'd0);
        check("cm_src",       {31'b0, data_src},   32'd1);
        check("cm_tag_valid", {28'b0, load_tag, set_valid}, 32'b1010);
        check("cm_clr_dirty", {30'b0, clr_dirty},  32'b10);
        tick();
        bus.pmem_resp = 1'b0;
        hit = 2'b10;
        #1;
        check("cm_recheck_resp", {31'b0, bus.mem_resp}, 32'd1);
        check("cm_recheck_prd",  {31'b0, bus.pmem_read}, 32'd0);
        tick();
        idle_inputs();
        tick();

        // Dirty write miss, victim way 0: writeback, fill, then write hit.
        bus.mem_write = 1'b1;
        bus.mem_byte_enable = 32'h0F00_0000;
        valid = 2'b01;
        dirty = 2'b01;
        lru = 1'b0;
        tick();
        check("dm_check_resp", {31'b0, bus.mem_resp}, 32'd0);
        tick();
        for (int unsigned i = 0; i < 2; i++) begin
            check("dm_wb_wait", {29'b0, bus.pmem_write, bus.pmem_addr_sel, bus.pmem_read}, 32'b110);
            check("dm_wb_noclr", {30'b0, clr_dirty}, 32'd0);
            tick();
        end
        bus.pmem_resp = 1'b1;
        #1;
        check("dm_wb_clr", {30'b0, clr_dirty}, 32'b01);
        check("dm_wb_tag", {30'b0, load_tag},  32'd0);
        tick();
        check("dm_fill", {29'b0, bus.pmem_write, bus.pmem_addr_sel, bus.pmem_read}, 32'b001);
        check("dm_fill_we0", data_we0, 32'hFFFF_FFFF);
        check("dm_fill_tag", {30'b0, load_tag}, 32'b01);
        tick();
        bus.pmem_resp = 1'b0;
        hit = 2'b01;
        dirty = 2'b00;
        #1;
        check("dm_resp",  {31'b0, bus.mem_resp}, 32'd1);
        check("dm_we0",   data_we0,              32'h0F00_0000);
        check("dm_dirty", {30'b0, set_dirty},    32'b01);
        tick();
        idle_inputs();
        tick();

`ifdef CACHE_PERF_CNT_EN
        check("pc_hit_cnt",  hit_cnt,  32'd1);
        check("pc_miss_cnt", miss_cnt, 32'd2);
        check("pc_wb_cnt",   wb_cnt,   32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
